// File: rtl/vedio_frame_sched.sv
// Capture sequencer: walks the sources selected in src_mask in ascending order
// and stores num frames from each, using vsync rising-to-active edges as frame boundaries.
module vedio_frame_sched #(
    parameter int FRM_W  = 8,
    parameter int TMO    = 3_000_000,
    parameter bit VS_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       src_mask,
    input  logic [FRM_W-1:0] frm_num,
    input  logic             vsync,
    output logic [1:0]       src_sel,
    output logic             src_en,
    output logic             store_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [FRM_W-1:0] frm_cnt
);
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             vs_d_q, vs_d_d;
    logic [3:0]       mask_q, mask_d;
    logic [FRM_W-1:0] num_q, num_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [1:0]       src_sel_q, src_sel_d;
    logic             src_en_q, src_en_d;
    logic             store_en_q, store_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;

    logic             fb;
    logic [3:0]       above;

    function automatic logic [1:0] low_bit(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    assign fb    = (vsync == VS_POL) && (vs_d_q != VS_POL);
    // Sources strictly above the current one; the walk never wraps downward.
    assign above = mask_q & (4'b1110 << src_sel_q);

    always_comb begin
        state_d    = state_q;
        vs_d_d     = vsync;
        mask_d     = mask_q;
        num_d      = num_q;
        tmo_d      = tmo_q;
        src_sel_d  = src_sel_q;
        src_en_d   = src_en_q;
        store_en_d = store_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        frm_cnt_d  = frm_cnt_q;

        if (state_q != S_IDLE && abort) begin
            state_d    = S_IDLE;
            src_en_d   = 1'b0;
            store_en_d = 1'b0;
            busy_d     = 1'b0;
            frm_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (src_mask == 4'd0) begin
                            err_d = 1'b1;
                        end else begin
                            mask_d    = src_mask;
                            num_d     = (frm_num == '0) ? FRM_W'(1) : frm_num;
                            src_sel_d = low_bit(src_mask);
                            src_en_d  = 1'b1;
                            busy_d    = 1'b1;
                            tmo_d     = '0;
                            state_d   = S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    // Timeout outranks a boundary arriving in the same cycle.
                    if (tmo_q == TW'(TMO - 1)) begin
                        err_d      = 1'b1;
                        src_sel_d  = 2'd0;
                        src_en_d   = 1'b0;
                        store_en_d = 1'b0;
                        busy_d     = 1'b0;
                        frm_cnt_d  = '0;
                        state_d    = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                        if (fb) begin
                            store_en_d = 1'b1;
                            frm_cnt_d  = '0;
                            state_d    = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (fb) begin
                        if (frm_cnt_q == num_q - FRM_W'(1)) begin
                            store_en_d = 1'b0;
                            state_d    = S_NEXT;
                        end else begin
                            frm_cnt_d = frm_cnt_q + FRM_W'(1);
                        end
                    end
                end
                S_NEXT: begin
                    if (above != 4'd0) begin
                        src_sel_d = low_bit(above);
                        frm_cnt_d = '0;
                        tmo_d     = '0;
                        state_d   = S_ARM;
                    end else begin
                        done_d     = 1'b1;
                        src_en_d   = 1'b0;
                        store_en_d = 1'b0;
                        busy_d     = 1'b0;
                        state_d    = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vs_d_q     <= ~VS_POL;
            mask_q     <= 4'd0;
            num_q      <= FRM_W'(1);
            tmo_q      <= '0;
            src_sel_q  <= 2'd0;
            src_en_q   <= 1'b0;
            store_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            frm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            vs_d_q     <= vs_d_d;
            mask_q     <= mask_d;
            num_q      <= num_d;
            tmo_q      <= tmo_d;
            src_sel_q  <= src_sel_d;
            src_en_q   <= src_en_d;
            store_en_q <= store_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            frm_cnt_q  <= frm_cnt_d;
        end
    end

    assign src_sel  = src_sel_q;
    assign src_en   = src_en_q;
    assign store_en = store_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign frm_cnt  = frm_cnt_q;

endmodule

// File: doc/vedio_frame_sched.md
VEDIO_FRAME_SCHED -- requirements
Module: vedio_frame_sched

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter FRM_W, default 8: width of the frames-per-source count.
REQ-003 Parameter TMO, default 3_000_000: clk cycles to wait in ARM for a frame boundary before the wait is declared failed.
REQ-004 Parameter VS_POL, default 1: active level of vsync (1 = active-high).
REQ-005 Port clk, input, 1 bit: clock; it is the source video clock.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port start, input, 1 bit: one-cycle request to begin a capture sequence.
REQ-008 Port abort, input, 1 bit: cancels any sequence in progress.
REQ-009 Port src_mask, input, 4 bits: bit i set means source file i is part of the sequence.
REQ-010 Port frm_num, input, FRM_W bits: frames to store per source; a value of 0 SHALL be treated as 1.
REQ-011 Port vsync, input, 1 bit: frame sync, already in the clk domain.
REQ-012 Port src_sel, output, 2 bits: selected source/store file index.
REQ-013 Port src_en, output, 1 bit: source generator enable.
REQ-014 Port store_en, output, 1 bit: frame store enable.
REQ-015 Port busy, output, 1 bit: high while a sequence is active.
REQ-016 Port done, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-017 Port err, output, 1 bit: one-cycle pulse for an empty mask or an ARM timeout.
REQ-018 Port frm_cnt, output, FRM_W bits: frames completed for the current source.

Function
REQ-019 The block SHALL register vsync into vs_d each cycle.
REQ-020 A frame boundary (fb) SHALL be the cycle in which vsync==VS_POL and vs_d!=VS_POL.
REQ-021 The FSM SHALL have exactly five states: IDLE, ARM, RUN, NEXT, DONE.
REQ-022 In IDLE with start=1 and src_mask==0, the block SHALL pulse err for one cycle and remain in IDLE.
REQ-023 In IDLE with start=1 and src_mask!=0, the block SHALL:
- latch src_mask into mask_q and max(frm_num,1) into num_q;
- set src_sel to the lowest set bit of src_mask;
- set src_en=1 and busy=1;
- clear the timeout counter;
- enter ARM.
REQ-024 In ARM, on fb the block SHALL set store_en=1, set frm_cnt=0 and enter RUN.
REQ-025 In ARM, when the timeout counter reaches TMO-1 without fb, the block SHALL pulse err, clear all outputs and enter IDLE.
REQ-026 An fb in the same cycle that start is accepted SHALL be ignored, so ARM waits for the next fb.
REQ-027 In RUN, each fb SHALL increment frm_cnt.
REQ-028 In RUN, when an fb occurs with frm_cnt==num_q-1, the block SHALL instead clear store_en and enter NEXT.
REQ-029 In NEXT, if mask_q has a set bit above src_sel, the block SHALL load src_sel with the lowest such bit, clear frm_cnt and the timeout counter, and enter ARM.
REQ-030 In NEXT, if mask_q has no set bit above src_sel, the block SHALL enter DONE.
REQ-031 In NEXT, src_sel SHALL NOT wrap to a lower index.
REQ-032 DONE SHALL last exactly one cycle: done=1, src_en=0, store_en=0, busy=0, then IDLE.
REQ-033 All outputs SHALL be registered, so store_en rises 1 cycle after the fb clock edge.
REQ-034 start SHALL be ignored in every state other than IDLE.
REQ-035 mask_q and num_q SHALL NOT be affected by changes to src_mask or frm_num during a sequence.
REQ-036 abort=1 in any non-IDLE state SHALL, on the next edge:
- enter IDLE;
- clear src_en, store_en, busy and frm_cnt;
- hold src_sel;
- pulse neither done nor err.
REQ-037 Priority within one cycle SHALL be rst > abort > timeout > fb.
REQ-038 The timeout counter SHALL saturate, never wrap, and count only while in ARM.

Reset
REQ-039 When rst=1 on a clock edge, the block SHALL enter IDLE and set src_sel=0, src_en=0, store_en=0, busy=0, done=0, err=0, frm_cnt=0, vs_d=~VS_POL and the timeout counter to 0.
REQ-040 Reset asserted mid-sequence SHALL take effect on that edge, with no done or err pulse.
REQ-041 The first fb after reset release SHALL require a vsync inactive-to-active transition; a vsync already active at reset release is not a boundary.

Verification
REQ-042 Reset: hold rst 5 cycles with vsync=1 -> all outputs 0 and src_sel=0; the first edge is detected only after vsync goes low then high.
REQ-043 Two sources: src_mask=4'b0101, frm_num=2, start, then 6 fb ->
- src_sel=0 with store_en high between fb1 and fb3;
- src_sel=2 from the cycle after NEXT, with store_en high between fb4 and fb6;
- done pulses 2 cycles after fb6;
- busy falls with done.
REQ-044 Empty mask and start while busy: src_mask=0 with start -> err pulses for 1 cycle and busy stays 0; a second start during RUN leaves state and frm_cnt unchanged.
REQ-045 Abort: abort asserted in RUN at frm_cnt=1 -> next cycle IDLE, store_en=0, busy=0, done=0, err=0.
REQ-046 Timeout: TMO=100, start, no vsync -> err pulses on the cycle after the 100th ARM cycle and busy=0.
REQ-047 Zero frame count: frm_num=0, src_mask=4'b1000 -> src_sel=3, store_en high for exactly one frame (fb1 to fb2), then done.
